// File: rtl/mat_mult_sequencer.sv
`timescale 1ns/1ps
// Sequencer for an external 2x2 nibble matrix multiplier: loads 8 operands, waits, drains 4 results.
// Latency: result w presented COMPUTE_CYCLES edges after the 8th operand handshake.
// Backpressure: out_ready low holds out_data/out_last stable; no operand accepted outside LOAD.
module mat_mult_sequencer #(
   parameter int COMPUTE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_data,
   output logic [31:0] op_bus,
   input  logic [31:0] res_bus,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic        busy,
   output logic [7:0]  done_count
);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Counter preload: the capture edge itself is counted, hence the minus one.
   localparam logic [3:0] WAIT_INIT = 4'(COMPUTE_CYCLES - 1);

   state_t      state;
   logic [2:0]  idx;       // next operand slot, 0=a .. 7=h
   logic [3:0]  wait_cnt;
   logic [31:0] res_q;     // captured {w,x,y,z}
   logic [1:0]  elem;      // element currently presented, 0=w .. 3=z
   logic [1:0]  elem_nxt;

   assign elem_nxt = elem + 2'd1;

   // Single FSM: all handshake and status outputs are registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= LOAD;
         idx        <= 3'd0;
         wait_cnt   <= 4'd0;
         op_bus     <= 32'd0;
         res_q      <= 32'd0;
         elem       <= 2'd0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_data   <= 8'd0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         done_count <= 8'd0;
      end else begin
         case (state)
            LOAD: begin
               if (in_valid && in_ready) begin
                  // Slot a sits in the top nibble, so slot index i maps to bit 4*(7-i).
                  op_bus[{~idx, 2'b00} +: 4] <= in_data;
                  busy <= 1'b1;
                  if (idx == 3'd7) begin
                     idx      <= 3'd0;
                     wait_cnt <= WAIT_INIT;
                     in_ready <= 1'b0;
                     state    <= WAIT;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  res_q     <= res_bus;
                  out_data  <= res_bus[31:24];
                  out_last  <= 1'b0;
                  out_valid <= 1'b1;
                  elem      <= 2'd0;
                  state     <= DRAIN;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (elem == 2'd3) begin
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     busy       <= 1'b0;
                     done_count <= done_count + 8'd1;
                     in_ready   <= 1'b1;
                     state      <= LOAD;
                  end else begin
                     // Element w is in the top byte, so element i maps to bit 8*(3-i).
                     elem     <= elem_nxt;
                     out_data <= res_q[{~elem_nxt, 3'b000} +: 8];
                     out_last <= (elem_nxt == 2'd3);
                  end
               end
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mat_mult_sequencer.sv
`timescale 1ns/1ps
// Bench for mat_mult_sequencer: two instances (settle 1 with combinational multiplier,
// settle 4 with a 3-stage multiplier), directed vectors, scoreboard-checked result stream.
module tb_mat_mult_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sel = 1'b0;           // 0 drives dut1, 1 drives dut4
   logic in_valid = 1'b0;
   logic [3:0] in_data = 4'd0;
   logic out_ready = 1'b0;

   logic        in_ready1, out_valid1, out_last1, busy1;
   logic [31:0] op_bus1, res_bus1;
   logic [7:0]  out_data1, done1;
   logic        in_ready4, out_valid4, out_last4, busy4;
   logic [31:0] op_bus4, res_bus4;
   logic [7:0]  out_data4, done4;
   logic [31:0] pipe1, pipe2, pipe3;

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   int z_cyc = 0;
   logic [8:0] sb[$];          // {last, data}

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference 2x2 multiplier, all arithmetic mod 256
   function automatic logic [31:0] mm(input logic [31:0] op);
      logic [7:0] a, b, c, d, e, f, g, h;
      a = {4'd0, op[31:28]}; b = {4'd0, op[27:24]}; c = {4'd0, op[23:20]}; d = {4'd0, op[19:16]};
      e = {4'd0, op[15:12]}; f = {4'd0, op[11:8]};  g = {4'd0, op[7:4]};   h = {4'd0, op[3:0]};
      return {a*e + b*g, a*f + b*h, c*e + d*g, c*f + d*h};
   endfunction

   assign res_bus1 = mm(op_bus1);

   // Three-cycle multiplier model for the slow instance
   always @(posedge clk) begin
      pipe1 <= op_bus4;
      pipe2 <= pipe1;
      pipe3 <= pipe2;
   end
   assign res_bus4 = mm(pipe3);

   mat_mult_sequencer #(.COMPUTE_CYCLES(1)) dut1 (
      .clk(clk), .reset(rst_n), .in_valid(in_valid & ~sel), .in_ready(in_ready1),
      .in_data(in_data), .op_bus(op_bus1), .res_bus(res_bus1), .out_valid(out_valid1),
      .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1), .busy(busy1),
      .done_count(done1));

   mat_mult_sequencer #(.COMPUTE_CYCLES(4)) dut4 (
      .clk(clk), .reset(rst_n), .in_valid(in_valid & sel), .in_ready(in_ready4),
      .in_data(in_data), .op_bus(op_bus4), .res_bus(res_bus4), .out_valid(out_valid4),
      .out_ready(out_ready), .out_data(out_data4), .out_last(out_last4), .busy(busy4),
      .done_count(done4));

   logic       c_in_ready, c_out_valid, c_out_last, c_busy;
   logic [7:0] c_out_data, c_done;
   assign c_in_ready  = sel ? in_ready4  : in_ready1;
   assign c_out_valid = sel ? out_valid4 : out_valid1;
   assign c_out_last  = sel ? out_last4  : out_last1;
   assign c_busy      = sel ? busy4      : busy1;
   assign c_out_data  = sel ? out_data4  : out_data1;
   assign c_done      = sel ? done4      : done1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every output handshake is compared against the scoreboard head
   always @(negedge clk) begin
      if (rst_n && c_out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", {23'd0, c_out_last, c_out_data}, 32'h1ff);
         end else begin
            logic [8:0] e;
            e = sb.pop_front();
            chk("result", {23'd0, c_out_last, c_out_data}, {23'd0, e});
            if (e[8]) z_cyc = cyc + 1;
         end
      end
   end

   task automatic send_nib(input logic [3:0] d, output int acc);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!c_in_ready && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      chk("in_ready_wait", {31'd0, c_in_ready}, 32'd1);
      @(posedge clk); #1;
      acc = cyc;
   endtask

   task automatic send_vec(input logic [31:0] v, input logic [31:0] exp, input bit hold,
                           output int first_acc);
      int acc;
      for (int i = 0; i < 4; i++)
         sb.push_back({(i == 3), exp[31 - 8*i -: 8]});
      first_acc = 0;
      for (int i = 0; i < 8; i++) begin
         send_nib(v[31 - 4*i -: 4], acc);
         if (i == 0) first_acc = acc;
      end
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!c_out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((c_busy || sb.size() != 0) && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_complete", sb.size(), 32'd0);
      chk("busy_idle", {31'd0, c_busy}, 32'd0);
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", {31'd0, c_out_valid}, 32'd0);
      chk("rst_busy", {31'd0, c_busy}, 32'd0);
      chk("rst_done", {24'd0, c_done}, 32'd0);
      sb.delete();
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int n, f1, f2;
      // T1: basic vector, settle 1
      #12.5 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_in_ready", {31'd0, c_in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, c_out_valid}, 32'd0);
      chk("reset_busy", {31'd0, c_busy}, 32'd0);
      chk("reset_done", {24'd0, c_done}, 32'd0);
      chk("reset_op_bus", op_bus1, 32'd0);
      out_ready = 1'b1;
      send_vec(32'h12345678, 32'h13162B32, 1'b0, f1);
      chk("busy_after_load", {31'd0, c_busy}, 32'd1);
      chk("in_ready_after_load", {31'd0, c_in_ready}, 32'd0);
      wait_valid(n);
      chk("latency_c1", n, 32'd1);
      wait_done();
      chk("done_t1", {24'd0, c_done}, 32'd1);

      // T2: all-5 and all-F vectors
      do_reset();
      send_vec(32'h55555555, 32'h32323232, 1'b0, f1);
      wait_done();
      send_vec(32'hFFFFFFFF, 32'hC2C2C2C2, 1'b0, f1);
      wait_done();
      chk("done_t2", {24'd0, c_done}, 32'd2);

      // T4: backpressure on y while in_valid toggles
      out_ready = 1'b0;
      send_vec(32'h12345678, 32'h13162B32, 1'b0, f1);
      wait_valid(n);
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_data  = 4'h9;
         chk("bp_y_data", {24'd0, c_out_data}, 32'h2B);
         chk("bp_y_last", {31'd0, c_out_last}, 32'd0);
         chk("bp_in_ready", {31'd0, c_in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_done();
      chk("done_t4", {24'd0, c_done}, 32'd3);

      // T5: reset mid-LOAD, then mid-DRAIN, then a clean load
      for (int i = 0; i < 5; i++) send_nib(4'(i + 10), n);
      in_valid = 1'b0;
      do_reset();
      out_ready = 1'b0;
      send_vec(32'hFFFFFFFF, 32'hC2C2C2C2, 1'b0, f1);
      wait_valid(n);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      do_reset();
      out_ready = 1'b1;
      send_vec(32'h12345678, 32'h13162B32, 1'b0, f1);
      wait_done();
      chk("done_t5", {24'd0, c_done}, 32'd1);

      // T6: back-to-back loads with in_valid held high
      do_reset();
      send_vec(32'h12345678, 32'h13162B32, 1'b1, f1);
      send_vec(32'h43218765, 32'h322B1613, 1'b0, f2);
      chk("b2b_start", f2, z_cyc + 1);
      wait_done();
      chk("done_t6", {24'd0, c_done}, 32'd2);

      // T3: settle 4 with three-cycle multiplier
      sel = 1'b1;
      do_reset();
      send_vec(32'h43218765, 32'h322B1613, 1'b0, f1);
      wait_valid(n);
      chk("latency_c4", n, 32'd4);
      wait_done();
      chk("done_t3", {24'd0, c_done}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
